// File: rtl/serdes_io_link.sv
// -----------------------------------------------------------------------------
// serdes_io_link
// Single-lane differential line driver and line receiver in one block.
//
// TX side: drives one bit per clock onto a complementary pair, supports forced
// electrical idle and a receiver-detect handshake (charge the line for
// DET_CYCLES, then sample the pad comparator once).
// RX side: registers the incoming pair, recovers the bit and flags electrical
// idle after IDLE_FILTER consecutive equal-pair cycles.
//
// Parameters:
//   DET_CYCLES  (1..255) common-mode charge cycles before the sense is sampled
//   IDLE_FILTER (1..15)  equal-pair cycles before RXIDLE asserts
//
// Ports:
//   TRANSCLK    in   clock, rising edge
//   RESET_N     in   synchronous active-low reset
//   data        in   TX bit
//   TXIDLE      in   request electrical idle
//   RXDET       in   start receiver detect
//   DET_SENSE   in   pad comparator, 1 = far-end termination present
//   LPBK        in   (SERDES_LOOPBACK_EN only) RX uses internal TX pair
//   RXDET_O     out  detect result, held until the next detect completes
//   RXDET_DONE  out  one-cycle pulse when RXDET_O is updated
//   TX_P/TX_N   out  line pair
//   RX_P/RX_N   in   line pair from link partner
//   RXIDLE      out  electrical idle seen on RX pair
//   data_out    out  recovered bit
//
// Optional build macro: SERDES_LOOPBACK_EN adds the LPBK input.
// -----------------------------------------------------------------------------
module serdes_io_link #(
  parameter int DET_CYCLES  = 4,
  parameter int IDLE_FILTER = 2
) (
  input  logic TRANSCLK,
  input  logic RESET_N,
  input  logic data,
  input  logic TXIDLE,
  input  logic RXDET,
  input  logic DET_SENSE,
`ifdef SERDES_LOOPBACK_EN
  input  logic LPBK,
`endif
  output logic RXDET_O,
  output logic RXDET_DONE,
  output logic TX_P,
  output logic TX_N,
  input  logic RX_P,
  input  logic RX_N,
  output logic RXIDLE,
  output logic data_out
);

  typedef enum logic [1:0] {
    ST_ACTIVE     = 2'd0,
    ST_ELEC_IDLE  = 2'd1,
    ST_DET_CHARGE = 2'd2,
    ST_DET_SAMPLE = 2'd3
  } tx_state_t;

  localparam logic [7:0] DET_LOAD = 8'(DET_CYCLES - 1);
  localparam logic [3:0] IDLE_MAX = 4'(IDLE_FILTER);

  // Pair levels for a given TX state: {P, N}
  function automatic logic [1:0] line_drive(input tx_state_t st, input logic d);
    logic [1:0] pair;
    case (st)
      ST_ACTIVE:     pair = {d, ~d};
      ST_ELEC_IDLE:  pair = 2'b00;
      ST_DET_CHARGE: pair = 2'b11;
      ST_DET_SAMPLE: pair = 2'b11;
      default:       pair = 2'b00;
    endcase
    return pair;
  endfunction

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic [7:0] r_det_cnt;
  logic [7:0] w_det_cnt_nxt;
  logic       w_det_sample;

  logic       w_rx_p;
  logic       w_rx_n;
  logic       r_rx_p;
  logic       r_rx_n;
  logic       w_rx_diff;
  logic [3:0] r_idle_cnt;
  logic [3:0] w_idle_cnt_nxt;

  // TX next-state: a running detect owns the lane; RXDET beats TXIDLE beats data
  always_comb begin
    w_state_nxt   = r_state;
    w_det_cnt_nxt = r_det_cnt;
    w_det_sample  = 1'b0;
    case (r_state)
      ST_DET_CHARGE: begin
        if (r_det_cnt == 8'd0) begin
          w_state_nxt = ST_DET_SAMPLE;
        end else begin
          w_det_cnt_nxt = r_det_cnt - 8'd1;
        end
      end
      ST_DET_SAMPLE: begin
        // RXDET is deliberately not looked at here so a held request
        // only re-triggers once the lane is back in ACTIVE/ELEC_IDLE.
        w_det_sample = 1'b1;
        if (TXIDLE) begin
          w_state_nxt = ST_ELEC_IDLE;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE, ST_ELEC_IDLE: begin
        if (RXDET) begin
          w_state_nxt   = ST_DET_CHARGE;
          w_det_cnt_nxt = DET_LOAD;
        end else if (TXIDLE) begin
          w_state_nxt = ST_ELEC_IDLE;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = ST_ELEC_IDLE;
      end
    endcase
  end

  // TX state, line drive (from next state) and detect result registers
  always_ff @(posedge TRANSCLK) begin
    if (!RESET_N) begin
      r_state    <= ST_ELEC_IDLE;
      r_det_cnt  <= 8'd0;
      TX_P       <= 1'b0;
      TX_N       <= 1'b0;
      RXDET_O    <= 1'b0;
      RXDET_DONE <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_det_cnt    <= w_det_cnt_nxt;
      {TX_P, TX_N} <= line_drive(w_state_nxt, data);
      RXDET_DONE   <= w_det_sample;
      if (w_det_sample) begin
        RXDET_O <= DET_SENSE;
      end
    end
  end

`ifdef SERDES_LOOPBACK_EN
  // Loopback taps the registered TX pair; the RX input register is the only filter
  assign w_rx_p = LPBK ? TX_P : RX_P;
  assign w_rx_n = LPBK ? TX_N : RX_N;
`else
  assign w_rx_p = RX_P;
  assign w_rx_n = RX_N;
`endif

  // Equal-pair run length, saturating at the filter length
  always_comb begin
    w_rx_diff = r_rx_p ^ r_rx_n;
    if (w_rx_diff) begin
      w_idle_cnt_nxt = 4'd0;
    end else if (r_idle_cnt == IDLE_MAX) begin
      w_idle_cnt_nxt = r_idle_cnt;
    end else begin
      w_idle_cnt_nxt = r_idle_cnt + 4'd1;
    end
  end

  // RX input register, idle detection and recovered bit
  always_ff @(posedge TRANSCLK) begin
    if (!RESET_N) begin
      r_rx_p     <= 1'b0;
      r_rx_n     <= 1'b0;
      r_idle_cnt <= 4'd0;
      RXIDLE     <= 1'b1;
      data_out   <= 1'b0;
    end else begin
      r_rx_p     <= w_rx_p;
      r_rx_n     <= w_rx_n;
      r_idle_cnt <= w_idle_cnt_nxt;
      // RXIDLE sets when the run saturates and clears only on a differential
      // pair, so it stays high straight out of reset on an idle line.
      if (w_rx_diff) begin
        RXIDLE <= 1'b0;
      end else if (w_idle_cnt_nxt == IDLE_MAX) begin
        RXIDLE <= 1'b1;
      end
      data_out <= w_rx_diff ? r_rx_p : 1'b0;
    end
  end

endmodule

// File: tb/tb_serdes_io_link.sv
module tb_serdes_io_link;

  localparam int DET_CYCLES  = 4;
  localparam int IDLE_FILTER = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, data, txidle, rxdet, det_sense;
  logic rxdet_o, rxdet_done, tx_p, tx_n, rxidle, data_out;
  logic tie_rx;
  logic rx_p, rx_n;
`ifdef SERDES_LOOPBACK_EN
  logic lpbk;
`endif

  // Link wired back to itself; tie_rx grounds the RX pads instead
  assign rx_p = tie_rx ? 1'b0 : tx_p;
  assign rx_n = tie_rx ? 1'b0 : tx_n;

  serdes_io_link #(.DET_CYCLES(DET_CYCLES), .IDLE_FILTER(IDLE_FILTER)) dut (
    .TRANSCLK  (clk),
    .RESET_N   (rst_n),
    .data      (data),
    .TXIDLE    (txidle),
    .RXDET     (rxdet),
    .DET_SENSE (det_sense),
`ifdef SERDES_LOOPBACK_EN
    .LPBK      (lpbk),
`endif
    .RXDET_O   (rxdet_o),
    .RXDET_DONE(rxdet_done),
    .TX_P      (tx_p),
    .TX_N      (tx_n),
    .RX_P      (rx_p),
    .RX_N      (rx_n),
    .RXIDLE    (rxidle),
    .data_out  (data_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: detect as a countdown of remaining high-drive cycles,
  // RX as "pair seen one cycle late" plus an unbounded equal-run length.
  int m_det_left;
  int m_eq_run;
  bit m_tx_p, m_tx_n, m_seen_p, m_seen_n;
  bit m_rxdet_o, m_done, m_idle, m_dout;

  task automatic model_edge();
    if (!rst_n) begin
      m_det_left = 0; m_eq_run = 0;
      m_tx_p = 0; m_tx_n = 0; m_seen_p = 0; m_seen_n = 0;
      m_rxdet_o = 0; m_done = 0; m_idle = 1; m_dout = 0;
    end else begin
      if (m_seen_p != m_seen_n) begin
        m_dout = m_seen_p; m_eq_run = 0; m_idle = 0;
      end else begin
        m_dout = 0; m_eq_run++;
        if (m_eq_run >= IDLE_FILTER) m_idle = 1;
      end
      m_seen_p = m_tx_p; m_seen_n = m_tx_n;
      m_done = 0;
      if (m_det_left > 1) begin
        m_det_left--; m_tx_p = 1; m_tx_n = 1;
      end else if (m_det_left == 1) begin
        m_det_left = 0; m_rxdet_o = det_sense; m_done = 1;
        m_tx_p = txidle ? 1'b0 : data; m_tx_n = txidle ? 1'b0 : ~data;
      end else if (rxdet) begin
        m_det_left = DET_CYCLES + 1; m_tx_p = 1; m_tx_n = 1;
      end else begin
        m_tx_p = txidle ? 1'b0 : data; m_tx_n = txidle ? 1'b0 : ~data;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_val("TX_P", tx_p, m_tx_p);
    check_val("TX_N", tx_n, m_tx_n);
    check_val("RXDET_O", rxdet_o, m_rxdet_o);
    check_val("RXDET_DONE", rxdet_done, m_done);
    check_val("RXIDLE", rxidle, m_idle);
    check_val("data_out", data_out, m_dout);
  endtask

  task automatic run_detect(input bit sense);
    int hi = 0;
    int dn = 0;
    txidle = 0; det_sense = sense;
    for (int i = 0; i < 12; i++) begin
      rxdet = (i < 2);
      data = 1'($urandom);
      cycle();
      if (tx_p && tx_n) hi++;
      if (rxdet_done) begin
        dn++;
        check_val("det_result_on_done", rxdet_o, sense);
      end
    end
    check_val("det_high_cycles", hi, DET_CYCLES + 1);
    check_val("det_done_pulses", dn, 1);
    check_val("det_result_held", rxdet_o, sense);
  endtask

  initial begin
    int dn;
    bit d_hist[$];
    rst_n = 0; data = 0; txidle = 0; rxdet = 0; det_sense = 0; tie_rx = 0;
`ifdef SERDES_LOOPBACK_EN
    lpbk = 0;
`endif
    cycle(); cycle();
    check_val("reset_RXIDLE", rxidle, 1);
    check_val("reset_TX_P", tx_p, 0);

    // Release with a short data pattern
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      data = (i != 1);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      data = 1'($urandom);
      cycle();
    end
    check_val("active_RXIDLE", rxidle, 0);

    // Electrical idle for 5 cycles, then back to data
    txidle = 1;
    for (int i = 0; i < 5; i++) begin
      data = 1'($urandom);
      cycle();
    end
    check_val("idle_RXIDLE", rxidle, 1);
    check_val("idle_data_out", data_out, 0);
    txidle = 0;
    for (int i = 0; i < 4; i++) begin
      data = 1'($urandom);
      cycle();
    end
    check_val("wake_RXIDLE", rxidle, 0);

    // Receiver detect with and without far-end termination
    run_detect(1'b1);
    run_detect(1'b0);
    run_detect(1'b1);

    // Reset a couple of cycles into a detect
    rxdet = 1; cycle();
    rxdet = 0; cycle(); cycle();
    rst_n = 0; cycle();
    check_val("abort_TX_P", tx_p, 0);
    check_val("abort_TX_N", tx_n, 0);
    check_val("abort_RXDET_O", rxdet_o, 0);
    check_val("abort_RXIDLE", rxidle, 1);
    rst_n = 1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (rxdet_done) dn++;
    end
    check_val("abort_no_done", dn, 0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      data      = 1'($urandom);
      if ($urandom_range(0, 9) == 0) txidle = ~txidle;
      rxdet     = ($urandom_range(0, 15) == 0);
      det_sense = 1'($urandom);
      cycle();
    end

`ifdef SERDES_LOOPBACK_EN
    // Internal loopback with the RX pads grounded
    rst_n = 1; txidle = 0; rxdet = 0;
    for (int i = 0; i < 6; i++) cycle();
    lpbk = 1; tie_rx = 1;
    for (int i = 0; i < 60; i++) begin
      data = 1'($urandom);
      cycle();
      d_hist.push_back(data);
      if (i >= 3) check_val("lpbk_data_out", data_out, d_hist[i - 2]);
    end
    lpbk = 0; tie_rx = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
